// File: rtl/bcd_pkg.sv
// bcd_pkg -- shared BCD definitions for the sequential BCD multiplier.
//   bcd_digit_t : one packed BCD digit
//   BCD_MAX     : largest legal digit value (9)
//   BCD_CORR    : decimal-adjust correction added to a digit sum above 9
//   state_t     : FSM state type, with the state constants ST_IDLE/ST_MUL/ST_DONE
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_MUL  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/bcd_digit_mult.sv
// bcd_digit_mult -- combinational A_DIGITS-digit x 1-digit BCD multiply.
// Ports:
//   a       in  4*A_DIGITS      multiplicand, packed BCD, LSD in [3:0]
//   digit   in  4               single BCD multiplier digit
//   product out 4*(A_DIGITS+1)  packed BCD partial product
module bcd_digit_mult
  import bcd_pkg::*;
#(
  parameter int unsigned A_DIGITS = 4
) (
  input  logic [4*A_DIGITS-1:0]     a,
  input  bcd_digit_t                digit,
  output logic [4*(A_DIGITS+1)-1:0] product
);

  // Per-digit a_i*d + carry is at most 81 + 8 = 89, so 7 bits suffice.
  logic [6:0] sum;
  logic [6:0] carry;

  always_comb begin
    product = '0;
    carry   = '0;
    sum     = '0;
    for (int unsigned i = 0; i < A_DIGITS; i++) begin
      sum = 7'(a[4*i +: 4]) * 7'(digit) + carry;
      product[4*i +: 4] = 4'(sum % 7'(BCD_MAX + 4'd1));
      carry = sum / 7'(BCD_MAX + 4'd1);
    end
    product[4*A_DIGITS +: 4] = 4'(carry);
  end

endmodule

// File: rtl/bcd_seq_multiplier.sv
// bcd_seq_multiplier -- sequential packed-BCD multiplier, one multiplier
// digit per clock, most significant digit first.
// Ports:
//   CLK     in   1                       clock, rising edge
//   RST     in   1                       synchronous active-high reset
//   START   in   1                       begin a multiplication (IDLE/DONE only)
//   NUM1    in   4*A_DIGITS              multiplicand, packed BCD
//   NUM2    in   4*B_DIGITS              multiplier, packed BCD
//   BUSY    out  1                       high while multiplying
//   DONE    out  1                       one-cycle result-valid pulse
//   PRODUCT out  4*(A_DIGITS+B_DIGITS)   registered packed BCD product
//   ERR     out  1                       invalid-digit flag, valid with DONE
// Build option: define BCD_INPUT_CHECK_EN to reject operands holding a
// nibble above 9 (PRODUCT=0, ERR=1); otherwise ERR is tied low.
module bcd_seq_multiplier
  import bcd_pkg::*;
#(
  parameter int unsigned A_DIGITS = 4,
  parameter int unsigned B_DIGITS = 2
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             START,
  input  logic [4*A_DIGITS-1:0]            NUM1,
  input  logic [4*B_DIGITS-1:0]            NUM2,
  output logic                             BUSY,
  output logic                             DONE,
  output logic [4*(A_DIGITS+B_DIGITS)-1:0] PRODUCT,
  output logic                             ERR
);

  localparam int unsigned PW = 4 * (A_DIGITS + B_DIGITS);
  localparam int unsigned CW = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1;

  state_t                   state;
  logic [4*A_DIGITS-1:0]    num1_q;
  logic [4*B_DIGITS-1:0]    num2_q;
  logic [PW-1:0]            acc;
  logic [CW-1:0]            cnt;
  logic [PW-1:0]            product_q;

  bcd_digit_t               cur_digit;
  logic [4*(A_DIGITS+1)-1:0] partial;
  logic [PW-1:0]            shifted;
  logic [PW-1:0]            addend;
  logic [PW-1:0]            acc_next;
  logic [4:0]               dsum;
  logic                     dcarry;
  logic                     last;

  // cnt counts processed digits; digit cnt is taken from the MSD end.
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < B_DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        cur_digit = num2_q[4*(B_DIGITS-1-i) +: 4];
      end
    end
  end

  bcd_digit_mult #(
    .A_DIGITS (A_DIGITS)
  ) u_digit_mult (
    .a       (num1_q),
    .digit   (cur_digit),
    .product (partial)
  );

  // acc*10 is a one-digit shift; the top digit is always zero here because
  // the full-width product never overflows.
  assign shifted = acc << 4;
  assign addend  = PW'(partial);

  // Digit-serial decimal add: binary add, then +6 and carry-out above 9.
  always_comb begin
    acc_next = '0;
    dcarry   = 1'b0;
    dsum     = '0;
    for (int unsigned i = 0; i < A_DIGITS + B_DIGITS; i++) begin
      dsum = 5'(shifted[4*i +: 4]) + 5'(addend[4*i +: 4]) + 5'(dcarry);
      if (dsum > 5'(BCD_MAX)) begin
        dsum   = dsum + 5'(BCD_CORR);
        dcarry = 1'b1;
      end else begin
        dcarry = 1'b0;
      end
      acc_next[4*i +: 4] = dsum[3:0];
    end
  end

  assign last = (cnt == CW'(B_DIGITS - 1));

`ifdef BCD_INPUT_CHECK_EN
  logic bad;
  logic err_q;

  always_comb begin
    bad = 1'b0;
    for (int unsigned i = 0; i < A_DIGITS; i++) begin
      if (num1_q[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
    for (int unsigned i = 0; i < B_DIGITS; i++) begin
      if (num2_q[4*i +: 4] > BCD_MAX) bad = 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      num1_q    <= '0;
      num2_q    <= '0;
      acc       <= '0;
      cnt       <= '0;
      product_q <= '0;
`ifdef BCD_INPUT_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            num1_q <= NUM1;
            num2_q <= NUM2;
            acc    <= '0;
            cnt    <= '0;
            state  <= ST_MUL;
          end else begin
            state  <= ST_IDLE;
          end
        end
        ST_MUL: begin
`ifdef BCD_INPUT_CHECK_EN
          // Operands are checked from their registered copies, so a rejected
          // request spends its first MUL cycle here and then reports DONE.
          if (bad) begin
            product_q <= '0;
            err_q     <= 1'b1;
            state     <= ST_DONE;
          end else begin
            acc <= acc_next;
            cnt <= cnt + CW'(1);
            if (last) begin
              product_q <= acc_next;
              err_q     <= 1'b0;
              state     <= ST_DONE;
            end
          end
`else
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (last) begin
            product_q <= acc_next;
            state     <= ST_DONE;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign BUSY    = (state == ST_MUL);
  assign DONE    = (state == ST_DONE);
  assign PRODUCT = product_q;
`ifdef BCD_INPUT_CHECK_EN
  assign ERR     = err_q;
`else
  assign ERR     = 1'b0;
`endif

endmodule
